// File: rtl/fpga_top_level.sv
// Two-layer 3x3 CNN accelerator: AXIS weight loader, frame buffer, L1 (4 cores) and L2 (1 core),
// one tap per cycle across all input channels, then 16-bit result pixels packed 4 per beat.
module fpga_top_level_lane #(
    parameter int NUM_IN_CHANNELS = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int ACCUM_WIDTH     = 32,
    parameter int TAPS            = 9,
    parameter int OC              = 2,
    parameter int LINE_W          = 1152,
    parameter int TW              = 4
) (
    input  logic [NUM_IN_CHANNELS-1:0][DATA_WIDTH-1:0] i_act,
    input  logic [LINE_W-1:0]                          i_wline,
    input  logic [TW-1:0]                              i_tap,
    output logic [OC-1:0][ACCUM_WIDTH-1:0]             o_psum
);
    logic [OC-1:0][NUM_IN_CHANNELS-1:0][DATA_WIDTH-1:0]   wsel;
    logic [OC-1:0][NUM_IN_CHANNELS-1:0][2*DATA_WIDTH:0]   prod;

    always_comb begin
        wsel = '0;
        for (int t = 0; t < TAPS; t++)
            if (i_tap == TW'(t))
                for (int o = 0; o < OC; o++)
                    for (int ic = 0; ic < NUM_IN_CHANNELS; ic++)
                        wsel[o][ic] = i_wline[((o*TAPS + t)*NUM_IN_CHANNELS + ic)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Activations are unsigned, weights signed: widen activation with a zero sign bit.
    always_comb begin
        prod   = '0;
        o_psum = '0;
        for (int o = 0; o < OC; o++)
            for (int ic = 0; ic < NUM_IN_CHANNELS; ic++) begin
                prod[o][ic] = $signed({1'b0, i_act[ic]}) * $signed(wsel[o][ic]);
                o_psum[o]   = o_psum[o] + ACCUM_WIDTH'($signed(prod[o][ic]));
            end
    end
endmodule

module fpga_top_level #(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int NUM_IN_CHANNELS = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int ACCUM_WIDTH     = 32,
    parameter int FILTER_SIZE     = 3,
    parameter int IMG_WIDTH       = 16,
    parameter int IMG_HEIGHT      = 16,
    parameter int BRAM_DEPTH      = 512
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_axis_img_tvalid,
    output logic                         s_axis_img_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_img_tdata,
    input  logic                         s_axis_img_tlast,
    input  logic                         s_axis_w_tvalid,
    output logic                         s_axis_w_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_w_tdata,
    input  logic                         s_axis_w_tlast,
    output logic                         m_axis_res_tvalid,
    input  logic                         m_axis_res_tready,
    output logic [AXIS_DATA_WIDTH-1:0]   m_axis_res_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_res_tkeep,
    output logic                         m_axis_res_tlast,
    input  logic                         i_load_weights,
    input  logic [3:0]                   i_target_layer,
    input  logic                         i_start_compute,
    input  logic [8:0]                   i_l1_weight_base,
    input  logic [8:0]                   i_l2_weight_base,
    output logic                         o_compute_done
);
    localparam int NUM_CORES = 4;
    localparam int OC        = 2;
    localparam int TAPS      = FILTER_SIZE * FILTER_SIZE;
    localparam int LINE_W    = OC * TAPS * NUM_IN_CHANNELS * DATA_WIDTH;
    localparam int BEATS     = LINE_W / AXIS_DATA_WIDTH;
    localparam int BW        = $clog2(BEATS);
    localparam int AW        = $clog2(BRAM_DEPTH);
    localparam int TGW       = $clog2(NUM_CORES + 1);
    localparam int NPIX      = IMG_WIDTH * IMG_HEIGHT;
    localparam int PIXW      = $clog2(NPIX);
    localparam int XW        = $clog2(IMG_WIDTH);
    localparam int YW        = $clog2(IMG_HEIGHT);
    localparam int KW        = $clog2(FILTER_SIZE);
    localparam int TW        = $clog2(TAPS);
    localparam int TX_BEATS  = NPIX / 4;
    localparam int TXW       = $clog2(TX_BEATS);

    typedef enum logic [2:0] {IDLE, RX_IMG, L1, L2, TX, DONE} state_e;

    logic [LINE_W-1:0]                 wmem [NUM_CORES+1][BRAM_DEPTH];
    logic [AXIS_DATA_WIDTH-1:0]        fbuf [NPIX];
    logic [AXIS_DATA_WIDTH-1:0]        ibuf [NPIX];
    logic [OC*DATA_WIDTH-1:0]          rbuf [NPIX];

    state_e                            state_q, state_d;
    logic [PIXW-1:0]                   cnt_q, cnt_d;
    logic [KW-1:0]                     kx_q, kx_d, ky_q, ky_d;
    logic [NUM_CORES-1:0][OC-1:0][ACCUM_WIDTH-1:0] acc_q, acc_d, psum;
    logic                              ld_arm_q, ld_arm_d;
    logic [3:0]                        ld_tgt_q, ld_tgt_d;
    logic [AW-1:0]                     ld_addr_q, ld_addr_d;
    logic [BW-1:0]                     ld_beat_q, ld_beat_d;
    logic [LINE_W-1:0]                 ld_line_q, ld_line_d, line_merged;
    logic                              w_we, last_tap, inb;
    logic [XW+1:0]                     sx;
    logic [YW+1:0]                     sy;
    logic [PIXW-1:0]                   addr;
    logic [TW-1:0]                     tap;
    logic [TXW-1:0]                    tx_idx;
    logic [NUM_IN_CHANNELS-1:0][DATA_WIDTH-1:0] act;
    logic [AXIS_DATA_WIDTH-1:0]        l1_word;
    logic [OC*DATA_WIDTH-1:0]          l2_word;
    logic                              unused_img_tlast;

    assign unused_img_tlast = s_axis_img_tlast;

    function automatic logic [DATA_WIDTH-1:0] relu_sat(input logic [ACCUM_WIDTH-1:0] a);
        if (a[ACCUM_WIDTH-1])                    return '0;
        if (|a[ACCUM_WIDTH-2:2*DATA_WIDTH])      return '1;
        return a[2*DATA_WIDTH-1:DATA_WIDTH];
    endfunction

    // Partial line is zero-padded because ld_line_q is cleared after every write.
    always_comb begin
        line_merged = ld_line_q;
        for (int k = 0; k < BEATS; k++)
            if (ld_beat_q == BW'(k))
                line_merged[k*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = s_axis_w_tdata;
        ld_arm_d  = ld_arm_q;
        ld_tgt_d  = ld_tgt_q;
        ld_addr_d = ld_addr_q;
        ld_beat_d = ld_beat_q;
        ld_line_d = ld_line_q;
        w_we      = 1'b0;
        if (i_load_weights) begin
            ld_arm_d  = 1'b1;
            ld_tgt_d  = i_target_layer;
            ld_addr_d = '0;
            ld_beat_d = '0;
            ld_line_d = '0;
        end else if (ld_arm_q && s_axis_w_tvalid) begin
            if (ld_beat_q == BW'(BEATS-1) || s_axis_w_tlast) begin
                w_we      = (ld_tgt_q <= 4'(NUM_CORES));
                ld_addr_d = ld_addr_q + 1'b1;
                ld_beat_d = '0;
                ld_line_d = '0;
                if (s_axis_w_tlast) ld_arm_d = 1'b0;
            end else begin
                ld_beat_d = ld_beat_q + 1'b1;
                ld_line_d = line_merged;
            end
        end
    end

    // Frame dimensions are powers of two, so the pixel counter splits directly into y:x.
    always_comb begin
        sx   = {2'b00, cnt_q[XW-1:0]} + (XW+2)'(kx_q) - (XW+2)'(FILTER_SIZE/2);
        sy   = {2'b00, cnt_q[PIXW-1:XW]} + (YW+2)'(ky_q) - (YW+2)'(FILTER_SIZE/2);
        inb  = (sx[XW+1:XW] == 2'b00) && (sy[YW+1:YW] == 2'b00);
        addr = {sy[YW-1:0], sx[XW-1:0]};
        tap  = TW'(ky_q) * TW'(FILTER_SIZE) + TW'(kx_q);
        act  = '0;
        if (inb) act = (state_q == L2) ? ibuf[addr] : fbuf[addr];
    end

    for (genvar n = 0; n < NUM_CORES; n++) begin : g_lane
        logic [LINE_W-1:0] wline;
        assign wline = (state_q == L2) ? ((n == 0) ? wmem[NUM_CORES][i_l2_weight_base] : '0)
                                       : wmem[n][i_l1_weight_base];
        fpga_top_level_lane #(
            .NUM_IN_CHANNELS(NUM_IN_CHANNELS), .DATA_WIDTH(DATA_WIDTH), .ACCUM_WIDTH(ACCUM_WIDTH),
            .TAPS(TAPS), .OC(OC), .LINE_W(LINE_W), .TW(TW)
        ) u_lane (
            .i_act  (act),
            .i_wline(wline),
            .i_tap  (tap),
            .o_psum (psum[n])
        );
    end

    assign last_tap = (kx_q == KW'(FILTER_SIZE-1)) && (ky_q == KW'(FILTER_SIZE-1));

    always_comb begin
        for (int n = 0; n < NUM_CORES; n++)
            for (int o = 0; o < OC; o++) begin
                acc_d[n][o] = ((kx_q == '0 && ky_q == '0) ? '0 : acc_q[n][o]) + psum[n][o];
                l1_word[(n*OC + o)*DATA_WIDTH +: DATA_WIDTH] = relu_sat(acc_d[n][o]);
            end
        l2_word = {relu_sat(acc_d[0][1]), relu_sat(acc_d[0][0])};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kx_d    = kx_q;
        ky_d    = ky_q;
        case (state_q)
            IDLE:   if (i_start_compute) begin
                        state_d = RX_IMG;
                        cnt_d   = '0;
                    end
            RX_IMG: if (s_axis_img_tvalid) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == PIXW'(NPIX-1)) begin
                            state_d = L1;
                            kx_d    = '0;
                            ky_d    = '0;
                        end
                    end
            L1, L2: if (kx_q == KW'(FILTER_SIZE-1)) begin
                        kx_d = '0;
                        if (ky_q == KW'(FILTER_SIZE-1)) begin
                            ky_d  = '0;
                            cnt_d = cnt_q + 1'b1;
                            if (cnt_q == PIXW'(NPIX-1))
                                state_d = (state_q == L1) ? L2 : TX;
                        end else begin
                            ky_d = ky_q + 1'b1;
                        end
                    end else begin
                        kx_d = kx_q + 1'b1;
                    end
            TX:     if (m_axis_res_tready) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == PIXW'(TX_BEATS-1)) begin
                            state_d = DONE;
                            cnt_d   = '0;
                        end
                    end
            DONE:   if (!i_start_compute || i_load_weights) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            kx_q      <= '0;
            ky_q      <= '0;
            acc_q     <= '0;
            ld_arm_q  <= 1'b0;
            ld_tgt_q  <= '0;
            ld_addr_q <= '0;
            ld_beat_q <= '0;
            ld_line_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            kx_q      <= kx_d;
            ky_q      <= ky_d;
            acc_q     <= acc_d;
            ld_arm_q  <= ld_arm_d;
            ld_tgt_q  <= ld_tgt_d;
            ld_addr_q <= ld_addr_d;
            ld_beat_q <= ld_beat_d;
            ld_line_q <= ld_line_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) wmem[ld_tgt_q[TGW-1:0]][ld_addr_q] <= line_merged;
        if (state_q == RX_IMG && s_axis_img_tvalid) fbuf[cnt_q] <= s_axis_img_tdata;
        if (state_q == L1 && last_tap) ibuf[cnt_q] <= l1_word;
        if (state_q == L2 && last_tap) rbuf[cnt_q] <= l2_word;
    end

    assign tx_idx            = cnt_q[TXW-1:0];
    assign s_axis_w_tready   = 1'b1;
    assign s_axis_img_tready = (state_q == RX_IMG);
    assign m_axis_res_tvalid = (state_q == TX);
    assign m_axis_res_tkeep  = (state_q == TX) ? '1 : '0;
    assign m_axis_res_tlast  = (state_q == TX) && (cnt_q == PIXW'(TX_BEATS-1));
    assign m_axis_res_tdata  = (state_q == TX) ? {rbuf[{tx_idx, 2'd3}], rbuf[{tx_idx, 2'd2}],
                                                  rbuf[{tx_idx, 2'd1}], rbuf[{tx_idx, 2'd0}]} : '0;
    assign o_compute_done    = (state_q == DONE);
endmodule

// File: tb/tb_fpga_top_level.sv
// Directed bench for fpga_top_level: loads weight lines, streams frames, and checks every
// result beat against a straightforward nested-loop convolution model.
module tb_fpga_top_level;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_axis_img_tvalid, s_axis_img_tready, s_axis_img_tlast;
    logic [63:0] s_axis_img_tdata;
    logic        s_axis_w_tvalid, s_axis_w_tready, s_axis_w_tlast;
    logic [63:0] s_axis_w_tdata;
    logic        m_axis_res_tvalid, m_axis_res_tready, m_axis_res_tlast;
    logic [63:0] m_axis_res_tdata;
    logic [7:0]  m_axis_res_tkeep;
    logic        i_load_weights, i_start_compute, o_compute_done;
    logic [3:0]  i_target_layer;
    logic [8:0]  i_l1_weight_base, i_l2_weight_base;

    always #5 clk = ~clk;

    fpga_top_level dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_img_tvalid(s_axis_img_tvalid), .s_axis_img_tready(s_axis_img_tready),
        .s_axis_img_tdata(s_axis_img_tdata), .s_axis_img_tlast(s_axis_img_tlast),
        .s_axis_w_tvalid(s_axis_w_tvalid), .s_axis_w_tready(s_axis_w_tready),
        .s_axis_w_tdata(s_axis_w_tdata), .s_axis_w_tlast(s_axis_w_tlast),
        .m_axis_res_tvalid(m_axis_res_tvalid), .m_axis_res_tready(m_axis_res_tready),
        .m_axis_res_tdata(m_axis_res_tdata), .m_axis_res_tkeep(m_axis_res_tkeep),
        .m_axis_res_tlast(m_axis_res_tlast),
        .i_load_weights(i_load_weights), .i_target_layer(i_target_layer),
        .i_start_compute(i_start_compute), .i_l1_weight_base(i_l1_weight_base),
        .i_l2_weight_base(i_l2_weight_base), .o_compute_done(o_compute_done)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    logic [7:0]  wt [5][144];
    logic [7:0]  stage [144];
    logic [63:0] img [256];
    logic [7:0]  l1 [256][8];
    logic [15:0] res [256];
    logic [63:0] first_beat;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] sat8(input int a);
        if (a < 0) return 8'h00;
        if ((a >>> 8) > 255) return 8'hFF;
        return 8'(a >>> 8);
    endfunction

    task automatic model();
        for (int p = 0; p < 256; p++)
            for (int ch = 0; ch < 8; ch++) begin
                int acc = 0;
                for (int t = 0; t < 9; t++) begin
                    int sx = p % 16 + t % 3 - 1;
                    int sy = p / 16 + t / 3 - 1;
                    if (sx >= 0 && sx < 16 && sy >= 0 && sy < 16)
                        for (int ic = 0; ic < 8; ic++) begin
                            logic [7:0] a = img[sy*16 + sx][8*ic +: 8];
                            logic [7:0] w = wt[ch/2][((ch%2)*9 + t)*8 + ic];
                            acc += int'(a) * int'($signed(w));
                        end
                end
                l1[p][ch] = sat8(acc);
            end
        for (int p = 0; p < 256; p++)
            for (int ch = 0; ch < 2; ch++) begin
                int acc = 0;
                for (int t = 0; t < 9; t++) begin
                    int sx = p % 16 + t % 3 - 1;
                    int sy = p / 16 + t / 3 - 1;
                    if (sx >= 0 && sx < 16 && sy >= 0 && sy < 16)
                        for (int ic = 0; ic < 8; ic++) begin
                            logic [7:0] a = l1[sy*16 + sx][ic];
                            logic [7:0] w = wt[4][(ch*9 + t)*8 + ic];
                            acc += int'(a) * int'($signed(w));
                        end
                end
                res[p][8*ch +: 8] = sat8(acc);
            end
    endtask

    task automatic clear_stage();
        for (int i = 0; i < 144; i++) stage[i] = 8'h00;
    endtask

    task automatic load_w(input int tgt, input int nb);
        @(negedge clk);
        i_load_weights = 1'b1;
        i_target_layer = 4'(tgt);
        @(negedge clk);
        i_load_weights = 1'b0;
        for (int k = 0; k < nb; k++) begin
            s_axis_w_tvalid = 1'b1;
            for (int b = 0; b < 8; b++) s_axis_w_tdata[8*b +: 8] = stage[8*k + b];
            s_axis_w_tlast = (k == nb - 1);
            @(negedge clk);
        end
        s_axis_w_tvalid = 1'b0;
        s_axis_w_tlast  = 1'b0;
        if (tgt <= 4)
            for (int i = 0; i < 144; i++) wt[tgt][i] = (i < nb*8) ? stage[i] : 8'h00;
    endtask

    task automatic send_img(input int n);
        for (int i = 0; i < n; i++) begin
            int to = 0;
            s_axis_img_tvalid = 1'b1;
            s_axis_img_tdata  = img[i];
            s_axis_img_tlast  = (i == 255);
            while (!s_axis_img_tready && to < 100) begin
                @(negedge clk);
                to++;
            end
            if (to >= 100) begin
                chk("rx_tready_timeout", 64'(s_axis_img_tready), 64'd1);
                break;
            end
            @(negedge clk);
        end
        s_axis_img_tvalid = 1'b0;
        s_axis_img_tlast  = 1'b0;
    endtask

    task automatic collect(input int stall_at);
        int to = 0;
        while (!m_axis_res_tvalid && to < 30000) begin
            @(negedge clk);
            to++;
        end
        if (to >= 30000) begin
            chk("tx_start_timeout", 64'(m_axis_res_tvalid), 64'd1);
            return;
        end
        for (int b = 0; b < 64; b++) begin
            logic [63:0] exp = {res[4*b+3], res[4*b+2], res[4*b+1], res[4*b]};
            to = 0;
            while (!m_axis_res_tvalid && to < 100) begin
                @(negedge clk);
                to++;
            end
            if (b == 0) begin
                first_beat = m_axis_res_tdata;
                chk("tkeep", 64'(m_axis_res_tkeep), 64'hFF);
            end
            if (b == stall_at)
                for (int s = 0; s < 10; s++) begin
                    chk($sformatf("stall_data[%0d]", s), m_axis_res_tdata, exp);
                    chk($sformatf("stall_last[%0d]", s), 64'(m_axis_res_tlast), 64'(b == 63));
                    @(negedge clk);
                end
            chk($sformatf("tx_data[%0d]", b), m_axis_res_tdata, exp);
            chk($sformatf("tx_last[%0d]", b), 64'(m_axis_res_tlast), 64'(b == 63));
            m_axis_res_tready = 1'b1;
            @(negedge clk);
            m_axis_res_tready = 1'b0;
        end
        chk("tx_no_extra", 64'(m_axis_res_tvalid), 64'd0);
        chk("done_set", 64'(o_compute_done), 64'd1);
        i_start_compute = 1'b0;
        @(negedge clk);
        chk("done_clear", 64'(o_compute_done), 64'd0);
    endtask

    task automatic run_frame(input int stall_at);
        model();
        @(negedge clk);
        i_start_compute = 1'b1;
        send_img(256);
        collect(stall_at);
    endtask

    initial begin
        rst_n = 1'b0;
        s_axis_img_tvalid = 1'b0; s_axis_img_tdata = '0; s_axis_img_tlast = 1'b0;
        s_axis_w_tvalid = 1'b0;   s_axis_w_tdata = '0;   s_axis_w_tlast = 1'b0;
        m_axis_res_tready = 1'b0; i_load_weights = 1'b0; i_target_layer = '0;
        i_start_compute = 1'b0;   i_l1_weight_base = '0; i_l2_weight_base = '0;
        first_beat = '0;
        repeat (3) @(negedge clk);
        chk("rst_w_tready", 64'(s_axis_w_tready), 64'd1);
        chk("rst_img_tready", 64'(s_axis_img_tready), 64'd0);
        chk("rst_tvalid", 64'(m_axis_res_tvalid), 64'd0);
        chk("rst_tdata", m_axis_res_tdata, 64'd0);
        chk("rst_tkeep", 64'(m_axis_res_tkeep), 64'd0);
        chk("rst_tlast", 64'(m_axis_res_tlast), 64'd0);
        chk("rst_done", 64'(o_compute_done), 64'd0);
        rst_n = 1'b1;

        // Ramp weights on every core, zero image.
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 144; i++) stage[i] = 8'(16*(t+1) + i/8);
            load_w(t, 18);
        end
        for (int i = 0; i < 256; i++) img[i] = 64'd0;
        run_frame(-1);
        chk("zero_beat0", first_beat, 64'd0);

        // Ramp image with the same weights.
        for (int i = 0; i < 256; i++) img[i] = 64'h0807060504030201 + 64'(i);
        run_frame(-1);

        // Centre-tap identity weights via short (zero-padded) lines; 0x80 image -> 0.
        for (int n = 0; n < 4; n++) begin
            clear_stage();
            for (int o = 0; o < 2; o++) stage[(o*9 + 4)*8 + 2*n + o] = 8'd1;
            load_w(n, 14);
        end
        clear_stage();
        stage[32]  = 8'd1;
        stage[105] = 8'd1;
        load_w(4, 14);
        for (int i = 0; i < 144; i++) stage[i] = 8'h7F;
        load_w(7, 18);
        for (int i = 0; i < 256; i++) img[i] = {8{8'h80}};
        run_frame(-1);
        chk("half_beat0", first_beat, 64'd0);

        // L1 saturation: 255*127*8 >> 8 = 1012 -> 255; L2 ch0 = 255*127>>8 = 0x7E, ch1 negative -> 0.
        for (int n = 0; n < 4; n++) begin
            clear_stage();
            for (int o = 0; o < 2; o++)
                for (int ic = 0; ic < 8; ic++) stage[(o*9 + 4)*8 + ic] = 8'd127;
            load_w(n, 14);
        end
        clear_stage();
        stage[32]  = 8'd127;
        stage[105] = 8'h80;
        load_w(4, 14);
        for (int i = 0; i < 256; i++) img[i] = {8{8'hFF}};
        run_frame(20);
        chk("sat_beat0", first_beat, 64'h007E007E007E007E);

        // Reset in the middle of image reception, then a full fresh frame.
        for (int i = 0; i < 256; i++) img[i] = 64'h0807060504030201 + 64'(i);
        @(negedge clk);
        i_start_compute = 1'b1;
        send_img(100);
        rst_n = 1'b0;
        i_start_compute = 1'b0;
        #1;
        chk("midrst_img_tready", 64'(s_axis_img_tready), 64'd0);
        chk("midrst_tvalid", 64'(m_axis_res_tvalid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(-1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
